// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared state encoding and default sizing for the tick timer
//   state_e          : IDLE / RUN / FIRE countdown states
//   DEF_CNT_W        : default width of load value and remaining count
//   DEF_SYNC_STAGES  : default synchronizer depth on the divided clock
//   DEF_STALL_LIMIT  : default CLK cycles without a tick before stall (STALL_DETECT_EN)
package tick_timer_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STALL_LIMIT = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIRE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_timer_if.sv
// tick_timer_if: command/status bundle between the elevator controller and the tick timer
//   start     : load load_val and start or restart the countdown
//   load_val  : delay in ticks
//   cancel    : abort countdown without done
//   tick      : one-CLK pulse per divided-clock rising edge
//   busy      : high while counting
//   done      : one-CLK pulse on expiry
//   remaining : ticks left, 0 when idle
//   stall     : sticky divided-clock-stopped flag
//   master modport = controller side, slave modport = timer side
interface tick_timer_if
    import tick_timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             start;
    logic             cancel;
    logic [CNT_W-1:0] load_val;
    logic             tick;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;
    logic             stall;

    modport master (
        output start, cancel, load_val,
        input  tick, busy, done, remaining, stall
    );

    modport slave (
        input  start, cancel, load_val,
        output tick, busy, done, remaining, stall
    );

endinterface

// File: rtl/tick_timer_sync.sv
// tick_sync: brings the divided clock ck into the CLK domain and emits a registered one-CLK tick per rising edge
//   CLK    : system clock
//   rst    : asynchronous active-low reset
//   ck_i   : divided slow clock, asynchronous level
//   tick_o : one-CLK pulse per ck rise, SYNC_STAGES+1 edges after first capture
module tick_sync
    import tick_timer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic CLK,
    input  logic rst,
    input  logic ck_i,
    output logic tick_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   primed_q;
    logic                   tick_q;

    // The first cycle after reset fills the whole chain and prev with the current
    // ck level, so a ck that is already high at reset release never looks like a rise.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            primed_q <= 1'b0;
            tick_q   <= 1'b0;
        end else if (!primed_q) begin
            sync_q   <= {SYNC_STAGES{ck_i}};
            prev_q   <= ck_i;
            primed_q <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ck_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            tick_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/tick_timer.sv
// tick_timer: turns divided-clock edges into ticks and counts them down from a loaded delay, pulsing done on expiry
//   CLK  : system clock
//   rst  : asynchronous active-low reset
//   ck_i : divided slow clock from the clock divider, asynchronous level
//   bus  : tick_timer_if.slave (start/load_val/cancel in; tick/busy/done/remaining/stall out)
//   Optional: define STALL_DETECT_EN to enable the sticky stall flag; otherwise stall is tied 0.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          ck_i,
    tick_timer_if.slave   bus
);

    if (SYNC_STAGES < 2 || STALL_LIMIT < 1) begin : g_bad_cfg
        $error("tick_timer: SYNC_STAGES must be >= 2 and STALL_LIMIT >= 1");
    end

    logic             tick;
    state_e           state_q;
    logic [CNT_W-1:0] remaining_q;

    tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK   (CLK),
        .rst   (rst),
        .ck_i  (ck_i),
        .tick_o(tick)
    );

    // Priority cancel > start > tick; cancel only matters while counting.
    // A count of 1 (or 0) on a tick expires instead of decrementing, so remaining never wraps.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.cancel) begin
                        state_q     <= IDLE;
                        remaining_q <= '0;
                    end else if (bus.start) begin
                        state_q     <= (bus.load_val == '0) ? FIRE : RUN;
                        remaining_q <= bus.load_val;
                    end else if (tick) begin
                        state_q     <= (remaining_q <= CNT_W'(1)) ? FIRE : RUN;
                        remaining_q <= (remaining_q <= CNT_W'(1)) ? '0 : remaining_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= bus.start ? ((bus.load_val == '0) ? FIRE : RUN) : IDLE;
                    remaining_q <= bus.start ? bus.load_val : '0;
                end
            endcase
        end
    end

    assign bus.tick      = tick;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == FIRE);
    assign bus.remaining = remaining_q;

`ifdef STALL_DETECT_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stall_q, stall_d;

    // Counts only cycles that stay in RUN with no tick and no restart; anything else clears it.
    always_comb begin
        stall_cnt_d = (state_q == RUN && !bus.cancel && !bus.start && !tick)
                    ? ((stall_cnt_q == SW'(STALL_LIMIT)) ? stall_cnt_q : stall_cnt_q + 1'b1)
                    : '0;
        stall_d     = bus.start ? 1'b0 : (stall_q | (stall_cnt_d == SW'(STALL_LIMIT)));
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.stall = stall_q;
`else
    assign bus.stall = 1'b0;
`endif

endmodule
